// File: rtl/fifo_enq_arbiter.sv
// fifo_enq_arbiter
//   Round-robin arbiter that shares one FIFO enqueue port (D_IN/ENQ/FULL_N/CLR)
//   among NREQ producers. Each cycle at most one valid requester is granted, and
//   its data slice is steered to the FIFO. When BURST > 1, a winner may hold the
//   port for up to BURST consecutive grants before the pointer rotates.
//
// Parameters
//   width  data width per requester and of FIFO_D_IN
//   NREQ   number of requesters (>= 2)
//   BURST  max consecutive grants to one owner (>= 1, 1 = pure round-robin)
//
// Ports
//   CLK, RST          clock; synchronous active-high reset
//   CLR               synchronous clear of arbiter state, forwarded as FIFO_CLR
//   REQ_VALID[i]      requester i has data; its data is REQ_DATA[i*width +: width]
//   REQ_READY[i]      one-hot (or zero) grant, combinational in the request cycle
//   FIFO_D_IN         granted slice, zero when nothing is granted
//   FIFO_ENQ          |REQ_READY
//   FIFO_FULL_N       FIFO can accept data
//   FIFO_CLR          equal to CLR
//   DBG_STATE         arbiter FSM state (0 = IDLE, 1 = LOCK)
//   STAT_SEL/STAT_CNT only with FIFO_ARB_STATS_EN defined: per-requester
//                     saturating 16-bit enqueue counters, read combinationally
//
// Handshake: a transfer from requester i happens in exactly the cycles where
//   REQ_VALID[i] & REQ_READY[i] is high at the rising edge of CLK. READY never
//   depends on a registered copy of VALID, so the handshake has zero latency.

module fifo_enq_arbiter #(
    parameter int width = 1,
    parameter int NREQ  = 2,
    parameter int BURST = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CLR,
    input  logic [NREQ-1:0]       REQ_VALID,
    input  logic [NREQ*width-1:0] REQ_DATA,
    output logic [NREQ-1:0]       REQ_READY,
    output logic [width-1:0]      FIFO_D_IN,
    output logic                  FIFO_ENQ,
    input  logic                  FIFO_FULL_N,
    output logic                  FIFO_CLR,
    output logic                  DBG_STATE
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] STAT_SEL,
    output logic [15:0]                                STAT_CNT
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(BURST + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    localparam logic [BW-1:0] BURST_C = BW'(BURST);

    logic [0:0]    state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [BW-1:0] bcnt;
    logic [BW-1:0] bcnt_inc;

    logic          blocked;
    logic          srch_found;
    logic [PW-1:0] srch_idx;
    logic          gnt_any;
    logic [PW-1:0] gnt_idx;

    // (base + k) mod NREQ without relying on NREQ being a power of two.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return PW'(s);
    endfunction

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
    endfunction

    assign blocked  = RST | CLR | ~FIFO_FULL_N;
    assign bcnt_inc = bcnt + 1'b1;
    assign FIFO_CLR  = CLR;
    assign DBG_STATE = state[0];

    // Round-robin search from ptr. Scanning the offsets downward lets the
    // smallest offset (closest to ptr) overwrite any later candidate.
    always_comb begin
        srch_found = 1'b0;
        srch_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (REQ_VALID[wrap_add(ptr, k)]) begin
                srch_found = 1'b1;
                srch_idx   = wrap_add(ptr, k);
            end
        end
    end

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (!blocked) begin
            if (state == ST_IDLE) begin
                gnt_any = srch_found;
                gnt_idx = srch_idx;
            end else begin
                // A locked owner never yields to others mid-burst.
                gnt_any = REQ_VALID[owner];
                gnt_idx = owner;
            end
        end
    end

    always_comb begin
        REQ_READY = '0;
        FIFO_D_IN = '0;
        if (gnt_any) begin
            REQ_READY = {{(NREQ-1){1'b0}}, 1'b1} << gnt_idx;
            FIFO_D_IN = REQ_DATA[int'(gnt_idx)*width +: width];
        end
    end

    assign FIFO_ENQ = |REQ_READY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            ptr   <= '0;
            owner <= '0;
            bcnt  <= '0;
        end else if (CLR) begin
            state <= ST_IDLE;
            ptr   <= '0;
            bcnt  <= '0;
        end else if (state == ST_IDLE) begin
            if (gnt_any) begin
                if (BURST == 1) begin
                    ptr <= next_idx(gnt_idx);
                end else begin
                    state <= ST_LOCK;
                    owner <= gnt_idx;
                    bcnt  <= BW'(1);
                end
            end
        end else if (FIFO_FULL_N) begin
            // With FULL_N low everything holds, so back-pressure cannot
            // shorten a burst.
            if (REQ_VALID[owner]) begin
                if (bcnt_inc == BURST_C) begin
                    state <= ST_IDLE;
                    bcnt  <= '0;
                    ptr   <= next_idx(owner);
                end else begin
                    bcnt <= bcnt_inc;
                end
            end else begin
                // Owner dropped out: release the port this cycle without granting.
                state <= ST_IDLE;
                bcnt  <= '0;
                ptr   <= next_idx(owner);
            end
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] stat_q [NREQ];

    always_ff @(posedge CLK) begin
        for (int i = 0; i < NREQ; i++) begin
            if (RST || CLR) begin
                stat_q[i] <= '0;
            end else if (REQ_VALID[i] && REQ_READY[i] && (stat_q[i] != 16'hFFFF)) begin
                stat_q[i] <= stat_q[i] + 16'd1;
            end
        end
    end

    always_comb begin
        STAT_CNT = '0;
        if (int'(STAT_SEL) < NREQ) STAT_CNT = stat_q[STAT_SEL];
    end
`endif

`ifndef SYNTHESIS
    a_no_enq_when_full: assert property (@(posedge CLK) !(FIFO_ENQ && !FIFO_FULL_N));
    a_ready_onehot0:    assert property (@(posedge CLK) $onehot0(REQ_READY));
`endif

endmodule
